// File: rtl/execute_bru_issue_pkg.sv
// Shared widths, payload/source records and the wakeup-match helper for the
// in-order branch-unit issue queue.
package execute_bru_issue_pkg;

    localparam int XLEN       = 32;
    localparam int IMM_W      = 26;
    localparam int ROB_W      = 4;
    localparam int FID_W      = 8;
    localparam int BRU_CMD_W  = 7;
    localparam int BAGU_CMD_W = 2;
    localparam int BP_PAT_W   = 2;

    typedef struct packed {
        logic [XLEN-1:0]       pc;
        logic [IMM_W-1:0]      imm;
        logic [FID_W-1:0]      fid;
        logic [ROB_W-1:0]      dst_rob;
        logic [BRU_CMD_W-1:0]  bru_cmd;
        logic [BAGU_CMD_W-1:0] bagu_cmd;
        logic [BP_PAT_W-1:0]   bp_pattern;
        logic                  bp_taken;
        logic                  bp_hit;
        logic [XLEN-1:0]       bp_target;
    } bru_payload_t;

    typedef struct packed {
        logic             ready;
        logic [ROB_W-1:0] rob;
        logic [XLEN-1:0]  value;
    } src_t;

    function automatic logic wb_hit(input logic wb_valid,
                                    input logic [ROB_W-1:0] wb_rob,
                                    input logic [ROB_W-1:0] tag);
        return wb_valid && (wb_rob == tag);
    endfunction

endpackage

// File: rtl/execute_bru_issue_if.sv
// Dispatch, wakeup, control and issue signals of the BRU issue queue.
interface execute_bru_issue_if;
    import execute_bru_issue_pkg::*;

    logic                  i_valid;
    logic                  o_ready;
    logic [XLEN-1:0]       i_pc;
    logic [IMM_W-1:0]      i_imm;
    logic [FID_W-1:0]      i_fid;
    logic [ROB_W-1:0]      i_dst_rob;
    logic [BRU_CMD_W-1:0]  i_bru_cmd;
    logic [BAGU_CMD_W-1:0] i_bagu_cmd;
    logic [BP_PAT_W-1:0]   i_bp_pattern;
    logic                  i_bp_taken;
    logic                  i_bp_hit;
    logic [XLEN-1:0]       i_bp_target;
    logic                  i_src0_ready;
    logic [ROB_W-1:0]      i_src0_rob;
    logic [XLEN-1:0]       i_src0_value;
    logic                  i_src1_ready;
    logic [ROB_W-1:0]      i_src1_rob;
    logic [XLEN-1:0]       i_src1_value;
    logic                  i_wb_valid;
    logic [ROB_W-1:0]      i_wb_rob;
    logic [XLEN-1:0]       i_wb_value;
    logic                  i_flush;
    logic                  i_stall;

    logic                  o_valid;
    logic [XLEN-1:0]       o_pc;
    logic [XLEN-1:0]       o_src0_value;
    logic [XLEN-1:0]       o_src1_value;
    logic [ROB_W-1:0]      o_dst_rob;
    logic [IMM_W-1:0]      o_imm;
    logic [FID_W-1:0]      o_fid;
    logic [BRU_CMD_W-1:0]  o_bru_cmd;
    logic [BAGU_CMD_W-1:0] o_bagu_cmd;
    logic [BP_PAT_W-1:0]   o_bp_pattern;
    logic                  o_bp_taken;
    logic                  o_bp_hit;
    logic [XLEN-1:0]       o_bp_target;

    modport slave (
        input  i_valid, i_pc, i_imm, i_fid, i_dst_rob, i_bru_cmd, i_bagu_cmd,
               i_bp_pattern, i_bp_taken, i_bp_hit, i_bp_target,
               i_src0_ready, i_src0_rob, i_src0_value,
               i_src1_ready, i_src1_rob, i_src1_value,
               i_wb_valid, i_wb_rob, i_wb_value, i_flush, i_stall,
        output o_ready, o_valid, o_pc, o_src0_value, o_src1_value, o_dst_rob,
               o_imm, o_fid, o_bru_cmd, o_bagu_cmd, o_bp_pattern, o_bp_taken,
               o_bp_hit, o_bp_target
    );

    modport master (
        output i_valid, i_pc, i_imm, i_fid, i_dst_rob, i_bru_cmd, i_bagu_cmd,
               i_bp_pattern, i_bp_taken, i_bp_hit, i_bp_target,
               i_src0_ready, i_src0_rob, i_src0_value,
               i_src1_ready, i_src1_rob, i_src1_value,
               i_wb_valid, i_wb_rob, i_wb_value, i_flush, i_stall,
        input  o_ready, o_valid, o_pc, o_src0_value, o_src1_value, o_dst_rob,
               o_imm, o_fid, o_bru_cmd, o_bagu_cmd, o_bp_pattern, o_bp_taken,
               o_bp_hit, o_bp_target
    );

endinterface

// File: rtl/execute_bru_issue_entry.sv
// One issue-queue slot: payload, two source operands and their wakeup capture.
module execute_bru_issue_entry
    import execute_bru_issue_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_en_i,
    input  logic                   pop_i,
    input  logic                   flush_i,
    input  bru_payload_t           payload_i,
    input  src_t [1:0]             src_i,
    input  logic                   wb_valid_i,
    input  logic [ROB_W-1:0]       wb_rob_i,
    input  logic [XLEN-1:0]        wb_value_i,
    output logic                   valid_o,
    output bru_payload_t           payload_o,
    output logic [1:0]             src_ready_o,
    output logic [1:0][XLEN-1:0]   src_value_o
);

    logic         valid_q;
    bru_payload_t payload_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
        end else if (flush_i) begin
            valid_q <= 1'b0;
        end else if (wr_en_i) begin
            valid_q <= 1'b1;
        end else if (pop_i) begin
            valid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            payload_q <= payload_i;
        end
    end

    assign valid_o   = valid_q;
    assign payload_o = payload_q;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_src
            logic             rdy_q, rdy_d;
            logic [ROB_W-1:0] tag_q;
            logic [XLEN-1:0]  val_q, val_d;

            // A source not ready at dispatch can still be satisfied by a
            // writeback landing in the very same cycle.
            always_comb begin
                rdy_d = rdy_q;
                val_d = val_q;
                if (wr_en_i) begin
                    rdy_d = src_i[gi].ready | wb_hit(wb_valid_i, wb_rob_i, src_i[gi].rob);
                    val_d = src_i[gi].ready ? src_i[gi].value : wb_value_i;
                end else if (valid_q && !rdy_q && wb_hit(wb_valid_i, wb_rob_i, tag_q)) begin
                    rdy_d = 1'b1;
                    val_d = wb_value_i;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rdy_q <= 1'b0;
                end else begin
                    rdy_q <= rdy_d;
                end
            end

            always_ff @(posedge clk) begin
                val_q <= val_d;
                if (wr_en_i) begin
                    tag_q <= src_i[gi].rob;
                end
            end

            assign src_ready_o[gi] = rdy_q;
            assign src_value_o[gi] = val_q;
        end
    endgenerate

endmodule

// File: rtl/execute_bru_issue.sv
// In-order BRU issue queue: dispatch at the tail, wakeup in every slot, issue
// only from the head once both operands are ready.
module execute_bru_issue
    import execute_bru_issue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                clk,
    input  logic                resetn,
    execute_bru_issue_if.slave  bus
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]   head_q, head_d, tail_q, tail_d;
    logic [AW-1:0] head_idx, tail_idx;
    logic          full, push, pop;
    logic          head_valid, head_ready;

    bru_payload_t  pl_in;
    src_t [1:0]    src_in;

    logic [DEPTH-1:0]      ent_valid;
    bru_payload_t          ent_pl  [DEPTH];
    logic [1:0]            ent_rdy [DEPTH];
    logic [1:0][XLEN-1:0]  ent_val [DEPTH];
    bru_payload_t          head_pl;

    assign head_idx = head_q[AW-1:0];
    assign tail_idx = tail_q[AW-1:0];

    // Full comes only from the registered pointers, so a same-cycle pop never
    // opens room for a dispatch.
    assign full = (head_idx == tail_idx) && (head_q[AW] != tail_q[AW]);
    assign push = bus.i_valid && !full && !bus.i_flush;

    assign head_valid = ent_valid[head_idx];
    assign head_ready = &ent_rdy[head_idx];
    assign pop        = head_valid && head_ready && !bus.i_stall && !bus.i_flush;

    always_comb begin
        pl_in.pc         = bus.i_pc;
        pl_in.imm        = bus.i_imm;
        pl_in.fid        = bus.i_fid;
        pl_in.dst_rob    = bus.i_dst_rob;
        pl_in.bru_cmd    = bus.i_bru_cmd;
        pl_in.bagu_cmd   = bus.i_bagu_cmd;
        pl_in.bp_pattern = bus.i_bp_pattern;
        pl_in.bp_taken   = bus.i_bp_taken;
        pl_in.bp_hit     = bus.i_bp_hit;
        pl_in.bp_target  = bus.i_bp_target;
    end

    assign src_in[0] = {bus.i_src0_ready, bus.i_src0_rob, bus.i_src0_value};
    assign src_in[1] = {bus.i_src1_ready, bus.i_src1_rob, bus.i_src1_value};

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            execute_bru_issue_entry u_entry (
                .clk         (clk),
                .rst_n       (resetn),
                .wr_en_i     (push && (tail_idx == AW'(gi))),
                .pop_i       (pop && (head_idx == AW'(gi))),
                .flush_i     (bus.i_flush),
                .payload_i   (pl_in),
                .src_i       (src_in),
                .wb_valid_i  (bus.i_wb_valid),
                .wb_rob_i    (bus.i_wb_rob),
                .wb_value_i  (bus.i_wb_value),
                .valid_o     (ent_valid[gi]),
                .payload_o   (ent_pl[gi]),
                .src_ready_o (ent_rdy[gi]),
                .src_value_o (ent_val[gi])
            );
        end
    endgenerate

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        if (bus.i_flush) begin
            head_d = '0;
            tail_d = '0;
        end else begin
            if (pop)  head_d = head_q + (AW+1)'(1);
            if (push) tail_d = tail_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            head_q <= '0;
            tail_q <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
        end
    end

    assign head_pl = ent_pl[head_idx];

    assign bus.o_ready      = !full;
    assign bus.o_valid      = pop;
    assign bus.o_pc         = head_pl.pc;
    assign bus.o_imm        = head_pl.imm;
    assign bus.o_fid        = head_pl.fid;
    assign bus.o_dst_rob    = head_pl.dst_rob;
    assign bus.o_bru_cmd    = head_pl.bru_cmd;
    assign bus.o_bagu_cmd   = head_pl.bagu_cmd;
    assign bus.o_bp_pattern = head_pl.bp_pattern;
    assign bus.o_bp_taken   = head_pl.bp_taken;
    assign bus.o_bp_hit     = head_pl.bp_hit;
    assign bus.o_bp_target  = head_pl.bp_target;
    assign bus.o_src0_value = ent_val[head_idx][0];
    assign bus.o_src1_value = ent_val[head_idx][1];

endmodule

// File: tb/tb_execute_bru_issue.sv
// Scoreboard bench for the BRU issue queue: table-driven single-op vectors plus
// hand-written sequences for wakeup, blocking, full, flush and reset.
module tb_execute_bru_issue;
    import execute_bru_issue_pkg::*;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    execute_bru_issue_if bus();

    execute_bru_issue #(.DEPTH(4)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] s0;
        logic [31:0] s1;
    } exp_t;

    typedef struct {
        logic [31:0] pc;
        logic        s0r;
        logic [3:0]  s0rob;
        logic [31:0] s0v;
        logic        s1r;
        logic [3:0]  s1rob;
        logic [31:0] s1v;
        logic        wbv;
        logic [3:0]  wbrob;
        logic [31:0] wbval;
        logic [31:0] e0;
        logic [31:0] e1;
    } vec_t;

    exp_t sb[$];
    vec_t vt[6];
    int total = 0;
    int bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, act, want);
        end else begin
            $display("ok   %s got=%h", name, act);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.i_valid    = 1'b0;
        bus.i_wb_valid = 1'b0;
        bus.i_flush    = 1'b0;
    endtask

    task automatic expect_out(input string name, input logic v, input logic r);
        #2;
        check({name, "_valid"}, {31'd0, bus.o_valid}, {31'd0, v});
        check({name, "_ready"}, {31'd0, bus.o_ready}, {31'd0, r});
    endtask

    task automatic drive(input logic [31:0] pc,
                         input logic s0r, input logic [3:0] s0rob, input logic [31:0] s0v,
                         input logic s1r, input logic [3:0] s1rob, input logic [31:0] s1v);
        bus.i_valid      = 1'b1;
        bus.i_pc         = pc;
        bus.i_imm        = pc[25:0] + 26'd1;
        bus.i_fid        = pc[9:2];
        bus.i_dst_rob    = pc[5:2];
        bus.i_bru_cmd    = pc[8:2];
        bus.i_bagu_cmd   = pc[3:2];
        bus.i_bp_pattern = pc[3:2];
        bus.i_bp_taken   = pc[2];
        bus.i_bp_hit     = 1'b1;
        bus.i_bp_target  = pc + 32'd8;
        bus.i_src0_ready = s0r;
        bus.i_src0_rob   = s0rob;
        bus.i_src0_value = s0v;
        bus.i_src1_ready = s1r;
        bus.i_src1_rob   = s1rob;
        bus.i_src1_value = s1v;
    endtask

    task automatic push_exp(input logic [31:0] pc, input logic [31:0] e0, input logic [31:0] e1);
        exp_t e;
        e.pc = pc;
        e.s0 = e0;
        e.s1 = e1;
        sb.push_back(e);
    endtask

    task automatic wb(input logic [3:0] rob, input logic [31:0] val);
        bus.i_wb_valid = 1'b1;
        bus.i_wb_rob   = rob;
        bus.i_wb_value = val;
    endtask

    // Issue monitor: every o_valid pops the scoreboard and compares the payload.
    always @(negedge clk) begin
        exp_t e;
        logic [25:0] imm_w;
        if (bus.o_valid === 1'b1) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected_issue got_pc=%h want=none", bus.o_pc);
            end else begin
                e = sb.pop_front();
                imm_w = e.pc[25:0] + 26'd1;
                if (bus.o_pc !== e.pc || bus.o_src0_value !== e.s0 || bus.o_src1_value !== e.s1 ||
                    bus.o_dst_rob !== e.pc[5:2] || bus.o_fid !== e.pc[9:2] || bus.o_imm !== imm_w ||
                    bus.o_bp_target !== e.pc + 32'd8) begin
                    bad++;
                    $display("FAIL issue got pc=%h s0=%h s1=%h rob=%h fid=%h want pc=%h s0=%h s1=%h rob=%h fid=%h",
                             bus.o_pc, bus.o_src0_value, bus.o_src1_value, bus.o_dst_rob, bus.o_fid,
                             e.pc, e.s0, e.s1, e.pc[5:2], e.pc[9:2]);
                end else begin
                    $display("issue pc=%h s0=%h s1=%h", bus.o_pc, bus.o_src0_value, bus.o_src1_value);
                end
            end
        end
    end

    initial begin
        bus.i_stall = 1'b0;
        bus.i_wb_rob = '0;
        bus.i_wb_value = '0;
        drive(32'h0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
        idle();

        vt[0] = '{32'h100, 1'b1, 4'd0, 32'h11,   1'b1, 4'd0, 32'h22, 1'b0, 4'd0, 32'h0,    32'h11,   32'h22};
        vt[1] = '{32'h104, 1'b0, 4'd2, 32'h0,    1'b1, 4'd0, 32'h33, 1'b1, 4'd2, 32'hAAAA, 32'hAAAA, 32'h33};
        vt[2] = '{32'h108, 1'b1, 4'd0, 32'h1,    1'b0, 4'd7, 32'h0,  1'b1, 4'd7, 32'h55,   32'h1,    32'h55};
        vt[3] = '{32'h10C, 1'b0, 4'd9, 32'h0,    1'b0, 4'd9, 32'h0,  1'b1, 4'd9, 32'h99,   32'h99,   32'h99};
        vt[4] = '{32'h110, 1'b1, 4'd4, 32'h77,   1'b1, 4'd1, 32'h78, 1'b1, 4'd4, 32'hBAD,  32'h77,   32'h78};
        vt[5] = '{32'h114, 1'b1, 4'd6, 32'hC0DE, 1'b1, 4'd6, 32'hF00D, 1'b1, 4'd3, 32'h123, 32'hC0DE, 32'hF00D};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", {31'd0, bus.o_valid}, 32'd0);
        check("rst_ready", {31'd0, bus.o_ready}, 32'd1);
        resetn = 1'b1;

        // Single-op vectors: dispatch, then issue exactly one cycle later
        for (int i = 0; i < 6; i++) begin
            drive(vt[i].pc, vt[i].s0r, vt[i].s0rob, vt[i].s0v, vt[i].s1r, vt[i].s1rob, vt[i].s1v);
            bus.i_wb_valid = vt[i].wbv;
            bus.i_wb_rob   = vt[i].wbrob;
            bus.i_wb_value = vt[i].wbval;
            push_exp(vt[i].pc, vt[i].e0, vt[i].e1);
            expect_out("vec_disp", 1'b0, 1'b1);
            step();
            idle();
            expect_out("vec_issue", 1'b1, 1'b1);
            step();
        end

        // Late wakeup: wb two cycles after dispatch, issue the cycle after wb
        drive(32'h200, 1'b0, 4'd3, 32'h0, 1'b1, 4'd0, 32'h2222);
        push_exp(32'h200, 32'hDEADBEEF, 32'h2222);
        expect_out("a_disp", 1'b0, 1'b1);
        step();
        idle();
        expect_out("a_wait", 1'b0, 1'b1);
        step();
        wb(4'd3, 32'hDEADBEEF);
        expect_out("a_wb", 1'b0, 1'b1);
        step();
        idle();
        expect_out("a_issue", 1'b1, 1'b1);
        step();

        // Blocked head holds back a ready younger entry
        drive(32'h300, 1'b0, 4'd5, 32'h0, 1'b1, 4'd0, 32'h3);
        push_exp(32'h300, 32'h5555, 32'h3);
        step();
        drive(32'h304, 1'b1, 4'd0, 32'h44, 1'b1, 4'd0, 32'h45);
        push_exp(32'h304, 32'h44, 32'h45);
        expect_out("b_blk0", 1'b0, 1'b1);
        step();
        idle();
        for (int k = 0; k < 3; k++) begin
            expect_out("b_blk", 1'b0, 1'b1);
            step();
        end
        wb(4'd5, 32'h5555);
        expect_out("b_wb", 1'b0, 1'b1);
        step();
        idle();
        expect_out("b_head", 1'b1, 1'b1);
        step();
        expect_out("b_young", 1'b1, 1'b1);
        step();
        expect_out("b_empty", 1'b0, 1'b1);
        step();

        // Fill under stall, fifth dispatch refused, drain in order
        bus.i_stall = 1'b1;
        for (int k = 0; k < 4; k++) begin
            drive(32'h400 + 32'(4 * k), 1'b1, 4'd0, 32'h4000 + 32'(k), 1'b1, 4'd0, 32'h4100 + 32'(k));
            push_exp(32'h400 + 32'(4 * k), 32'h4000 + 32'(k), 32'h4100 + 32'(k));
            expect_out("c_fill", 1'b0, 1'b1);
            step();
        end
        drive(32'h4FC, 1'b1, 4'd0, 32'hEEEE, 1'b1, 4'd0, 32'hEEEE);
        expect_out("c_full", 1'b0, 1'b0);
        step();
        idle();
        bus.i_stall = 1'b0;
        expect_out("c_rel", 1'b1, 1'b0);
        step();
        for (int k = 0; k < 3; k++) begin
            expect_out("c_drain", 1'b1, 1'b1);
            step();
        end
        expect_out("c_empty", 1'b0, 1'b1);
        step();

        // Simultaneous dispatch and issue keeps occupancy at three
        bus.i_stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            drive(32'h800 + 32'(4 * k), 1'b1, 4'd0, 32'h80 + 32'(k), 1'b1, 4'd0, 32'h81);
            push_exp(32'h800 + 32'(4 * k), 32'h80 + 32'(k), 32'h81);
            step();
        end
        bus.i_stall = 1'b0;
        for (int k = 3; k < 6; k++) begin
            drive(32'h800 + 32'(4 * k), 1'b1, 4'd0, 32'h80 + 32'(k), 1'b1, 4'd0, 32'h81);
            push_exp(32'h800 + 32'(4 * k), 32'h80 + 32'(k), 32'h81);
            expect_out("f_steady", 1'b1, 1'b1);
            step();
        end
        idle();
        repeat (4) step();

        // Flush with a same-cycle dispatch drops everything
        bus.i_stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            drive(32'h500 + 32'(4 * k), 1'b1, 4'd0, 32'h50, 1'b0, 4'hA, 32'h0);
            push_exp(32'h500 + 32'(4 * k), 32'h50, 32'hA0);
            step();
        end
        bus.i_stall = 1'b0;
        drive(32'h5FC, 1'b1, 4'd0, 32'h5F, 1'b1, 4'd0, 32'h5F);
        bus.i_flush = 1'b1;
        wb(4'hA, 32'hA0);
        sb.delete();
        expect_out("d_flush", 1'b0, 1'b1);
        step();
        idle();
        wb(4'hA, 32'hA0);
        expect_out("d_empty", 1'b0, 1'b1);
        step();
        idle();
        expect_out("d_quiet", 1'b0, 1'b1);
        step();
        drive(32'h600, 1'b1, 4'd0, 32'h60, 1'b1, 4'd0, 32'h61);
        push_exp(32'h600, 32'h60, 32'h61);
        step();
        idle();
        expect_out("d_after", 1'b1, 1'b1);
        step();

        // Asynchronous reset in the middle of operation
        bus.i_stall = 1'b1;
        for (int k = 0; k < 2; k++) begin
            drive(32'h700 + 32'(4 * k), 1'b1, 4'd0, 32'h70, 1'b1, 4'd0, 32'h71);
            push_exp(32'h700 + 32'(4 * k), 32'h70, 32'h71);
            step();
        end
        idle();
        bus.i_stall = 1'b0;
        #1;
        resetn = 1'b0;
        #1;
        sb.delete();
        check("e_rst_valid", {31'd0, bus.o_valid}, 32'd0);
        check("e_rst_ready", {31'd0, bus.o_ready}, 32'd1);
        step();
        resetn = 1'b1;
        drive(32'h780, 1'b1, 4'd0, 32'h78, 1'b1, 4'd0, 32'h79);
        push_exp(32'h780, 32'h78, 32'h79);
        step();
        idle();
        expect_out("e_first", 1'b1, 1'b1);
        step();

        repeat (3) step();
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
